memory_layer_ctrl: RTL and testbench



---
 rtl/memory_layer_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_memory_layer_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_layer_ctrl.sv
// ---------------------------------------------------------------------------
// memory_layer_ctrl
//
// Sequencing FSM for the GAM memory-layer datapath. One `start` runs one
// learning step: class-size check, nearest-two scan over the class nodes,
// threshold test, and then either a new-node insert or a winner update
// followed by connection creation.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start                   request a learning step (sampled only in IDLE)
//   comparator_c            datapath compare result A (mux5) vs B (mux6)
//   busy                    high from LOAD through FIN
//   done, learning_done     coincident one-cycle pulses in FIN
//   ld_upcounter, en_upcounter, en_node_counter, en_connection, en_2min
//                           datapath counter / register enables
//   X_c, C_c, W_c, T_c, M_c memory field selects
//   RD_WR_c                 memory direction (RD unless writing)
//   mux1_sel..mux6_sel, demux_sel  datapath selects
//   ins_count, upd_count    (only with MEMORY_LAYER_CTRL_STATS_EN) saturating
//                           counts of inserts and updates
//
// Build option: define MEMORY_LAYER_CTRL_STATS_EN to add the statistics
// counters and their output ports.
// ---------------------------------------------------------------------------
package GAM_package;
    typedef enum logic [1:0] {LT = 2'd0, EQ = 2'd1, GT = 2'd2} comparator_T;
    typedef enum logic {RD = 1'b0, WR = 1'b1} RD_WR_T;
endpackage

module memory_layer_ctrl
    import GAM_package::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  comparator_T comparator_c,
    output logic        busy,
    output logic        done,
`ifdef MEMORY_LAYER_CTRL_STATS_EN
    output logic [15:0] ins_count,
    output logic [15:0] upd_count,
`endif
    output logic        ld_upcounter,
    output logic        en_upcounter,
    output logic        en_node_counter,
    output logic        en_connection,
    output logic        en_2min,
    output logic        learning_done,
    output logic        X_c,
    output logic        C_c,
    output logic        W_c,
    output logic        T_c,
    output logic        M_c,
    output RD_WR_T      RD_WR_c,
    output logic [1:0]  mux1_sel,
    output logic [1:0]  mux2_sel,
    output logic [1:0]  mux3_sel,
    output logic [1:0]  mux4_sel,
    output logic [1:0]  mux5_sel,
    output logic [1:0]  mux6_sel,
    output logic [1:0]  demux_sel
);

    typedef enum logic [3:0] {
        IDLE, LOAD, CHK, SRD, SED, SCMP, R1, TCMP, R2, W1, W2, CONN, INS, FIN
    } state_t;

    state_t state, state_nxt;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_nxt
        // unassigned and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: state_nxt = CHK;
            // upcounter (1) >= class count means zero or one node: insert
            CHK:  state_nxt = (comparator_c == LT) ? SRD : INS;
            SRD:  state_nxt = SED;
            SED:  state_nxt = SCMP;
            // upcounter already incremented: keep scanning while <= count
            SCMP: state_nxt = (comparator_c == GT) ? R1 : SRD;
            R1:   state_nxt = TCMP;
            // min1_ED above the winner's threshold means a novel input
            TCMP: state_nxt = (comparator_c == GT) ? INS : R2;
            R2:   state_nxt = W1;
            W1:   state_nxt = W2;
            W2:   state_nxt = CONN;
            CONN: state_nxt = FIN;
            INS:  state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic. Outputs are forced to their idle values while rst_n is
    // low so that no memory write leaves the block during a reset cycle.
    always_comb begin
        busy            = 1'b0;
        done            = 1'b0;
        learning_done   = 1'b0;
        ld_upcounter    = 1'b0;
        en_upcounter    = 1'b0;
        en_node_counter = 1'b0;
        en_connection   = 1'b0;
        en_2min         = 1'b0;
        X_c             = 1'b0;
        C_c             = 1'b0;
        W_c             = 1'b0;
        T_c             = 1'b0;
        M_c             = 1'b0;
        RD_WR_c         = RD;
        mux1_sel        = 2'd0;
        mux2_sel        = 2'd0;
        mux3_sel        = 2'd0;
        mux4_sel        = 2'd0;
        mux5_sel        = 2'd0;
        mux6_sel        = 2'd0;
        demux_sel       = 2'd0;
        if (rst_n) begin
            busy = (state != IDLE);
            unique case (state)
                LOAD: ld_upcounter = 1'b1;
                CHK, SCMP: begin
                    mux5_sel = 2'd1;
                    mux6_sel = 2'd1;
                end
                SRD: begin
                    mux1_sel = 2'd1;
                    X_c      = 1'b1;
                end
                SED: begin
                    en_2min      = 1'b1;
                    en_upcounter = 1'b1;
                end
                R1: begin
                    mux1_sel  = 2'd2;
                    W_c       = 1'b1;
                    T_c       = 1'b1;
                    M_c       = 1'b1;
                    demux_sel = 2'd1;
                end
                TCMP: begin
                    mux5_sel = 2'd2;
                    mux6_sel = 2'd2;
                end
                R2: begin
                    mux1_sel  = 2'd3;
                    W_c       = 1'b1;
                    demux_sel = 2'd2;
                end
                W1: begin
                    mux1_sel = 2'd2;
                    W_c      = 1'b1;
                    T_c      = 1'b1;
                    M_c      = 1'b1;
                    RD_WR_c  = WR;
                    mux2_sel = 2'd1;
                    mux3_sel = 2'd2;
                    mux4_sel = 2'd1;
                end
                W2: begin
                    mux1_sel = 2'd3;
                    W_c      = 1'b1;
                    RD_WR_c  = WR;
                    mux2_sel = 2'd2;
                end
                CONN: en_connection = 1'b1;
                INS: begin
                    X_c             = 1'b1;
                    C_c             = 1'b1;
                    W_c             = 1'b1;
                    T_c             = 1'b1;
                    M_c             = 1'b1;
                    RD_WR_c         = WR;
                    en_node_counter = 1'b1;
                end
                FIN: begin
                    done          = 1'b1;
                    learning_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MEMORY_LAYER_CTRL_STATS_EN
    // Saturating step statistics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ins_count <= '0;
            upd_count <= '0;
        end else begin
            if (state == INS && ins_count != 16'hFFFF) ins_count <= ins_count + 16'd1;
            if (state == CONN && upd_count != 16'hFFFF) upd_count <= upd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_memory_layer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_memory_layer_ctrl
//
// Bench for memory_layer_ctrl. A small datapath model (upcounter plus
// comparator) answers comparator_c. Each issued step pushes its expected
// signature into a scoreboard; a monitor accumulates what the DUT does and
// compares against the scoreboard entry whenever `done` is seen.
// ---------------------------------------------------------------------------
module tb_memory_layer_ctrl;
    import GAM_package::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    comparator_T comparator_c;
    logic        busy, done, ld_upcounter, en_upcounter, en_node_counter;
    logic        en_connection, en_2min, learning_done;
    logic        X_c, C_c, W_c, T_c, M_c;
    RD_WR_T      RD_WR_c;
    logic [1:0]  mux1_sel, mux2_sel, mux3_sel, mux4_sel, mux5_sel, mux6_sel, demux_sel;
`ifdef MEMORY_LAYER_CTRL_STATS_EN
    logic [15:0] ins_count, upd_count;
`endif

    memory_layer_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .comparator_c(comparator_c),
        .busy(busy), .done(done),
`ifdef MEMORY_LAYER_CTRL_STATS_EN
        .ins_count(ins_count), .upd_count(upd_count),
`endif
        .ld_upcounter(ld_upcounter), .en_upcounter(en_upcounter),
        .en_node_counter(en_node_counter), .en_connection(en_connection),
        .en_2min(en_2min), .learning_done(learning_done),
        .X_c(X_c), .C_c(C_c), .W_c(W_c), .T_c(T_c), .M_c(M_c),
        .RD_WR_c(RD_WR_c),
        .mux1_sel(mux1_sel), .mux2_sel(mux2_sel), .mux3_sel(mux3_sel),
        .mux4_sel(mux4_sel), .mux5_sel(mux5_sel), .mux6_sel(mux6_sel),
        .demux_sel(demux_sel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- datapath model ----------------
    int unsigned upcnt = 0;
    int unsigned class_count = 0;
    bit          tcmp_gt = 1'b0;

    always @(posedge clk) begin
        if (ld_upcounter)      upcnt <= 1;
        else if (en_upcounter) upcnt <= upcnt + 1;
    end

    always_comb begin
        comparator_c = EQ;
        if (mux5_sel == 2'd1 && mux6_sel == 2'd1)
            comparator_c = (upcnt < class_count) ? LT : (upcnt == class_count) ? EQ : GT;
        else if (mux5_sel == 2'd2 && mux6_sel == 2'd2)
            comparator_c = tcmp_gt ? GT : LT;
    end

    // Write code {X,C,W,T,M,mux1,mux2,mux3,mux4}; read code {mux1,demux,X,C,W,T,M}
    localparam logic [12:0] WC_INS = {5'b11111, 2'd0, 2'd0, 2'd0, 2'd0};
    localparam logic [12:0] WC_W1  = {5'b00111, 2'd2, 2'd1, 2'd2, 2'd1};
    localparam logic [12:0] WC_W2  = {5'b00100, 2'd3, 2'd2, 2'd0, 2'd0};
    localparam int RC_SRD = int'({2'd1, 2'd0, 5'b10000});
    localparam int RC_R1  = int'({2'd2, 2'd1, 5'b00111});
    localparam int RC_R2  = int'({2'd3, 2'd2, 5'b00100});

    typedef struct {
        int          lat;
        int          n2min;
        int          nconn;
        int          nnode;
        int          nwr;
        logic [12:0] w0;
        logic [12:0] w1;
        int          rsig;
    } exp_t;

    exp_t sb[$];

    // ---------------- monitor ----------------
    int          m_cyc, m_2min, m_conn, m_node, m_wr, m_rsig;
    logic [12:0] m_w0, m_w1;
    int          done_cnt = 0;

    task automatic mon_clear();
        m_cyc = 0; m_2min = 0; m_conn = 0; m_node = 0; m_wr = 0; m_rsig = 0;
        m_w0 = '0; m_w1 = '0;
    endtask

    initial mon_clear();

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            mon_clear();
        end else begin
            if (busy)            m_cyc++;
            if (en_2min)         m_2min++;
            if (en_connection)   m_conn++;
            if (en_node_counter) m_node++;
            if (RD_WR_c == WR) begin
                if (m_wr == 0)      m_w0 = {X_c, C_c, W_c, T_c, M_c, mux1_sel, mux2_sel, mux3_sel, mux4_sel};
                else if (m_wr == 1) m_w1 = {X_c, C_c, W_c, T_c, M_c, mux1_sel, mux2_sel, mux3_sel, mux4_sel};
                m_wr++;
            end else if (X_c | C_c | W_c | T_c | M_c) begin
                m_rsig += int'({mux1_sel, demux_sel, X_c, C_c, W_c, T_c, M_c});
            end
            if (learning_done != done)
                check("learning_done_vs_done", {31'd0, learning_done}, {31'd0, done});
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_done_pending", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("latency",        m_cyc,  e.lat);
                    check("en_2min_cycles", m_2min, e.n2min);
                    check("en_connection",  m_conn, e.nconn);
                    check("en_node_counter",m_node, e.nnode);
                    check("write_count",    m_wr,   e.nwr);
                    check("write0_code",    {19'd0, m_w0}, {19'd0, e.w0});
                    check("write1_code",    {19'd0, m_w1}, {19'd0, e.w1});
                    check("read_signature", m_rsig, e.rsig);
                end
                mon_clear();
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [27:0] all_outs();
        return {busy, done, ld_upcounter, en_upcounter, en_node_counter, en_connection,
                en_2min, learning_done, X_c, C_c, W_c, T_c, M_c, RD_WR_c,
                mux1_sel, mux2_sel, mux3_sel, mux4_sel, mux5_sel, mux6_sel, demux_sel};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int budget);
        int base;
        bit seen;
        base = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done_cnt != base) seen = 1'b1;
        end
        check("done_within_budget", {31'd0, seen}, 32'd1);
    endtask

    int exp_ins = 0;
    int exp_upd = 0;

    // n: class node count; gt: TCMP verdict; hold: keep start high all step
    task automatic run_step(input int n, input bit gt, input bit hold);
        exp_t e;
        class_count = n;
        tcmp_gt     = gt;
        e.w1 = '0;
        if (n <= 1) begin
            e.lat = 4; e.n2min = 0; e.nconn = 0; e.nnode = 1; e.nwr = 1;
            e.w0 = WC_INS; e.rsig = 0;
            exp_ins++;
        end else if (gt) begin
            e.lat = 3 * n + 6; e.n2min = n; e.nconn = 0; e.nnode = 1; e.nwr = 1;
            e.w0 = WC_INS; e.rsig = n * RC_SRD + RC_R1;
            exp_ins++;
        end else begin
            e.lat = 3 * n + 9; e.n2min = n; e.nconn = 1; e.nnode = 0; e.nwr = 2;
            e.w0 = WC_W1; e.w1 = WC_W2; e.rsig = n * RC_SRD + RC_R1 + RC_R2;
            exp_upd++;
        end
        sb.push_back(e);
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_done(200);
        // now in the cycle after FIN; start (if held) was ignored in FIN
        check("busy_after_fin", {31'd0, busy}, 32'd0);
        start = 1'b0;
        tick();
        tick();
        check("idle_after_step", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int  base;
        bit  found;

        // Reset held three cycles
        rst_n = 1'b0;
        repeat (3) tick();
        check("outputs_in_reset", {4'd0, all_outs()}, 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();
        check("outputs_idle_no_start", {4'd0, all_outs()}, 32'd0);

        run_step(0, 1'b0, 1'b0);  // empty class: insert, done at T+4
        run_step(1, 1'b0, 1'b0);  // single node: insert
        run_step(3, 1'b0, 1'b0);  // scan 3, update, done at T+18
        run_step(3, 1'b1, 1'b1);  // scan 3, novel, start held, done at T+15
        run_step(2, 1'b0, 1'b0);  // scan 2, update

`ifdef MEMORY_LAYER_CTRL_STATS_EN
        check("ins_count", {16'd0, ins_count}, exp_ins);
        check("upd_count", {16'd0, upd_count}, exp_upd);
`endif

        // Reset for one cycle during the SRD of node 2
        class_count = 3;
        tcmp_gt     = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (mux1_sel == 2'd1 && X_c && upcnt == 2) found = 1'b1;
            else tick();
        end
        check("reached_srd_node2", {31'd0, found}, 32'd1);
        base = done_cnt;
        rst_n = 1'b0;
        #1;
        check("no_write_in_reset_cycle", {31'd0, RD_WR_c}, {31'd0, RD});
        check("outputs_in_reset_cycle", {4'd0, all_outs()}, 32'd0);
        tick();
        rst_n = 1'b1;
        check("busy_after_midop_reset", {31'd0, busy}, 32'd0);
        repeat (5) tick();
        check("idle_after_midop_reset", {4'd0, all_outs()}, 32'd0);
        check("no_done_after_abort", done_cnt, base);
        exp_ins = 0;
        exp_upd = 0;

        run_step(1, 1'b0, 1'b0);  // recovery after reset
`ifdef MEMORY_LAYER_CTRL_STATS_EN
        check("ins_count_after_reset", {16'd0, ins_count}, exp_ins);
        check("upd_count_after_reset", {16'd0, upd_count}, exp_upd);
`endif
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
